// File: rtl/sd_join_pkg.sv
// Shared types for the sd_join synchronising join.
package sd_join_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } join_state_t;

endpackage

// File: rtl/sd_join_if.sv
// srdy/drdy bundle for sd_join: mirror input lanes plus the joined output.
interface sd_join_if #(
  parameter int mirror = 2,
  parameter int width  = 128
);
  logic [mirror-1:0]       c_srdy;
  logic [mirror-1:0]       c_drdy;
  logic [mirror*width-1:0] c_data;
  logic [mirror-1:0]       c_src_vld;
  logic                    p_srdy;
  logic                    p_drdy;
  logic [mirror*width-1:0] p_data;

  modport master (
    output c_srdy, c_data, c_src_vld, p_drdy,
    input  c_drdy, p_srdy, p_data
  );

  modport slave (
    input  c_srdy, c_data, c_src_vld, p_drdy,
    output c_drdy, p_srdy, p_data
  );
endinterface

// File: rtl/sd_join_lane.sv
// One join lane: holding register plus held flag; a load wins over a clear so
// a lane can re-arm in the same edge its previous item is released.
module sd_join_lane #(
  parameter int width = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [width-1:0] d,
  output logic [width-1:0] q,
  output logic             held
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      held <= 1'b0;
    else if (load)  held <= 1'b1;
    else if (clear) held <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) q <= d;
  end

endmodule

// File: rtl/sd_join.sv
// Synchronising join of mirror srdy/drdy lanes into one concatenated item.
// SD_JOIN_OVERLAP_EN adds an output register so the next set collects meanwhile.
// state   | meaning
// COLLECT | gathering lane items (overlap build: output register empty)
// OUTPUT  | joined item presented on p_srdy/p_data
module sd_join
  import sd_join_pkg::*;
#(
  parameter int mirror = 2,
  parameter int width  = 128
) (
  input  logic     clk,
  input  logic     reset,
  sd_join_if.slave bus
);

  logic [mirror-1:0]       emask;
  logic [mirror-1:0]       held;
  logic [mirror-1:0]       xfer;
  logic [mirror*width-1:0] hold_data;
  logic [mirror*width-1:0] joined;
  logic                    clear_all;
  join_state_t             state, state_nxt;

  // An all-zero mask means every lane takes part.
  assign emask = (bus.c_src_vld == '0) ? '1 : bus.c_src_vld;
  assign xfer  = bus.c_srdy & bus.c_drdy;

  for (genvar i = 0; i < mirror; i++) begin : g_lane
    sd_join_lane #(.width(width)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (xfer[i]),
      .clear (clear_all),
      .d     (bus.c_data[i*width +: width]),
      .q     (hold_data[i*width +: width]),
      .held  (held[i])
    );
    assign joined[i*width +: width] = emask[i] ? hold_data[i*width +: width] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

`ifdef SD_JOIN_OVERLAP_EN
  logic                    all_held;
  logic                    out_free;
  logic                    fire;
  logic [mirror*width-1:0] out_data;

  assign all_held = ((held & emask) == emask);
  assign out_free = (state == COLLECT) | bus.p_drdy;
  assign fire     = all_held & out_free;

  assign bus.c_drdy = emask & (~held | {mirror{fire}});
  assign bus.p_srdy = (state == OUTPUT);
  assign bus.p_data = out_data;

  always_ff @(posedge clk) begin
    if (fire) out_data <= joined;
  end

  always_comb begin
    state_nxt = state;
    clear_all = fire;
    if (fire)                               state_nxt = OUTPUT;
    else if (state == OUTPUT && bus.p_drdy) state_nxt = COLLECT;
  end
`else
  assign bus.c_drdy = (state == COLLECT) ? (emask & ~held) : '0;
  assign bus.p_srdy = (state == OUTPUT);
  assign bus.p_data = joined;

  // Completion is judged on the held flags as they will be after this edge.
  always_comb begin
    state_nxt = state;
    clear_all = 1'b0;
    if (state == COLLECT) begin
      if (((held | xfer) & emask) == emask) state_nxt = OUTPUT;
    end else if (bus.p_drdy) begin
      state_nxt = COLLECT;
      clear_all = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_join.sv
// Directed bench for sd_join; expectations follow the SD_JOIN_OVERLAP_EN setting.
module tb_sd_join;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   n;

  always #5 clk = ~clk;

  sd_join_if #(.mirror(2), .width(128)) bus2 ();
  sd_join_if #(.mirror(3), .width(8))   bus3 ();

  sd_join #(.mirror(2), .width(128)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  sd_join #(.mirror(3), .width(8)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack2(input logic [127:0] hi, input logic [127:0] lo);
    return {hi, lo};
  endfunction

  initial begin
    reset          = 1'b1;
    bus2.c_srdy    = '0;
    bus2.c_data    = '0;
    bus2.c_src_vld = '0;
    bus2.p_drdy    = 1'b0;
    bus3.c_srdy    = '0;
    bus3.c_data    = '0;
    bus3.c_src_vld = 3'b101;
    bus3.p_drdy    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psrdy", bus2.p_srdy, 1'b0);
    check("rst_cdrdy", bus2.c_drdy, 2'b11);
    check("rst_cdrdy3", bus3.c_drdy, 3'b101);
    reset = 1'b0;
    next_cycle();

`ifndef SD_JOIN_OVERLAP_EN
    // lanes arrive on different cycles
    n = 0;
    for (int t = 0; t <= 6; t++) begin
      bus2.p_drdy = 1'b1;
      bus2.c_srdy = {t == 3, t == 0};
      bus2.c_data = pack2(128'hB, 128'hA);
      @(negedge clk);
      if (t == 0) check("t1_drdy0_t0", bus2.c_drdy[0], 1'b1);
      if (t >= 1 && t <= 4) check("t1_drdy0", bus2.c_drdy[0], 1'b0);
      check("t1_psrdy", bus2.p_srdy, t == 4);
      if (t == 4) check("t1_pdata", bus2.p_data, pack2(128'hB, 128'hA));
      if (bus2.p_srdy && bus2.p_drdy) n++;
      next_cycle();
    end
    check("t1_count", n, 1);

    // simultaneous arrival, consumer stalls until t=5
    for (int t = 0; t <= 8; t++) begin
      bus2.c_srdy = (t <= 6) ? 2'b11 : 2'b00;
      bus2.c_data = (t == 0) ? pack2(128'h22, 128'h11) : pack2(128'h44, 128'h33);
      bus2.p_drdy = (t >= 5);
      @(negedge clk);
      check("t2_psrdy", bus2.p_srdy, (t >= 1 && t <= 5) || t == 7);
      check("t2_cdrdy", bus2.c_drdy, (t == 0 || t == 6 || t == 8) ? 2'b11 : 2'b00);
      if (t >= 1 && t <= 5) check("t2_pdata_stable", bus2.p_data, pack2(128'h22, 128'h11));
      if (t == 7) check("t2_pdata_next", bus2.p_data, pack2(128'h44, 128'h33));
      next_cycle();
    end
    bus2.c_srdy = '0;

    // three lanes, lane1 masked out but asserting srdy
    bus3.p_drdy = 1'b1;
    for (int t = 0; t <= 5; t++) begin
      bus3.c_srdy = {t == 2, 1'b1, t == 0};
      bus3.c_data = {8'h03, 8'hFF, 8'h01};
      @(negedge clk);
      if (t == 0) check("t3_cdrdy_t0", bus3.c_drdy, 3'b101);
      check("t3_drdy1", bus3.c_drdy[1], 1'b0);
      check("t3_psrdy", bus3.p_srdy, t == 3);
      if (t == 3) check("t3_pdata", bus3.p_data, 24'h030001);
      next_cycle();
    end
    bus3.c_srdy = '0;

    // reset mid-collect drops the partial set
    bus2.p_drdy = 1'b1;
    bus2.c_srdy = 2'b01;
    bus2.c_data = pack2(128'h0, 128'h55);
    next_cycle();
    bus2.c_srdy = 2'b00;
    @(negedge clk);
    check("t4_pre_cdrdy", bus2.c_drdy, 2'b10);
    #3;
    reset = 1'b1;
    #1;
    check("t4_rst_psrdy", bus2.p_srdy, 1'b0);
    check("t4_rst_cdrdy", bus2.c_drdy, 2'b11);
    next_cycle();
    reset = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      bus2.c_srdy = {t == 0, t == 3};
      bus2.c_data = pack2(128'hC, 128'hD);
      @(negedge clk);
      check("t4_psrdy", bus2.p_srdy, t == 4);
      if (t == 4) check("t4_pdata", bus2.p_data, pack2(128'hC, 128'hD));
      next_cycle();
    end
    bus2.c_srdy = '0;
`else
    // back-to-back streaming
    for (int t = 0; t <= 8; t++) begin
      bus2.p_drdy = 1'b1;
      bus2.c_srdy = (t <= 4) ? 2'b11 : 2'b00;
      bus2.c_data = pack2(128'(32'h20 + t), 128'(32'h10 + t));
      @(negedge clk);
      if (t <= 4) check("t5_cdrdy", bus2.c_drdy, 2'b11);
      check("t5_psrdy", bus2.p_srdy, t >= 2 && t <= 6);
      if (t >= 2 && t <= 6)
        check("t5_pdata", bus2.p_data, pack2(128'(32'h20 + t - 2), 128'(32'h10 + t - 2)));
      next_cycle();
    end

    // output stalls for 10 cycles with a second set collected behind it
    for (int t = 0; t <= 13; t++) begin
      bus2.p_drdy = (t >= 10);
      bus2.c_srdy = (t <= 10) ? 2'b11 : 2'b00;
      bus2.c_data = pack2(128'(32'h80 + t), 128'(32'h40 + t));
      @(negedge clk);
      check("t6_cdrdy", bus2.c_drdy, (t <= 1 || t >= 10) ? 2'b11 : 2'b00);
      check("t6_psrdy", bus2.p_srdy, t >= 2 && t <= 12);
      if (t >= 2 && t <= 10) check("t6_pdata0", bus2.p_data, pack2(128'h80, 128'h40));
      if (t == 11) check("t6_pdata1", bus2.p_data, pack2(128'h81, 128'h41));
      if (t == 12) check("t6_pdata2", bus2.p_data, pack2(128'h8A, 128'h4A));
      next_cycle();
    end
    bus2.c_srdy = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
